irq_nmi_ctrl: RTL

- Memory-mapped interrupt controller on the cpu6502 bus; directly upstream of the CPU, drives its irq and nmi inputs.
- Collects up to 8 peripheral interrupt sources, each edge or level mode, with per-source enables and a 6502-compatible active-low level IRQ.
- Converts a dedicated NMI source into clean, spaced active-low NMI pulses.
- Exposes PEND, ENABLE, MODE and VECT registers at four consecutive addresses for firmware service routines.

---
 rtl/irq_nmi_ctrl_if.sv | 13 +
 rtl/irq_nmi_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/irq_nmi_ctrl_if.sv
// CPU-side bus of the interrupt controller: address, write data and strobes in,
// chip select and register read data out.
interface irq_nmi_ctrl_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic        phi2;
    logic        sel;
    logic [7:0]  rdata;

    modport master (output addr, wdata, rw, phi2, input sel, rdata);
    modport slave  (input addr, wdata, rw, phi2, output sel, rdata);
endinterface

// File: rtl/irq_nmi_ctrl.sv
// 6502 interrupt controller: up to 8 edge/level IRQ sources with enables and a
// priority vector, plus an NMI pulse shaper with minimum spacing between pulses.
module irq_nmi_ctrl #(
    parameter int unsigned NSRC      = 8,
    parameter logic [15:0] BASE      = 16'hD000,
    parameter int unsigned NMI_PULSE = 4,
    parameter int unsigned NMI_GAP   = 2
) (
    input  logic            clk,
    input  logic            reset,
    irq_nmi_ctrl_if.slave   bus,
    input  logic [NSRC-1:0] src,
    input  logic            nmi_src,
    output logic            irq,
    output logic            nmi
);
    localparam logic [7:0]  MASK = 8'((9'd1 << NSRC) - 9'd1);
    localparam int unsigned CMAX = (NMI_PULSE > NMI_GAP) ? NMI_PULSE : NMI_GAP;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, GAP = 2'd2} nmi_state_e;

    logic [7:0]    src8, src_q;
    logic [7:0]    pend, enable, mode;
    logic [7:0]    pend_nx, enable_nx, mode_nx;
    logic [7:0]    active, vect;
    logic [1:0]    off;
    logic          phi2_q, in_range, wr;
    logic          nmi_src_q, nmi_edge, nmi_pend, nmi_pend_nx, nmi_nx;
    logic [CW-1:0] cnt, cnt_nx;
    nmi_state_e    state, state_nx;

    assign src8     = 8'(src);
    assign off      = bus.addr[1:0];
    assign in_range = ({1'b0, bus.addr} >= {1'b0, BASE}) &&
                      ({1'b0, bus.addr} <= ({1'b0, BASE} + 17'd3));
    // One write per store: only the clk where phi2 has just risen qualifies.
    assign wr       = in_range && !bus.rw && bus.phi2 && !phi2_q;
    assign bus.sel  = in_range && bus.rw;

    always_comb begin
        pend_nx   = '0;
        enable_nx = enable;
        mode_nx   = mode;
        if (wr && off == 2'd1) enable_nx = bus.wdata & MASK;
        if (wr && off == 2'd2) mode_nx   = bus.wdata & MASK;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!mode[i])
                pend_nx[i] = src8[i];
            else
                pend_nx[i] = (src8[i] & ~src_q[i]) |
                             (pend[i] & ~(wr && off == 2'd0 && bus.wdata[i]));
        end
        pend_nx = pend_nx & MASK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend   <= '0;
            enable <= '0;
            mode   <= MASK;
            src_q  <= '0;
            phi2_q <= 1'b0;
            irq    <= 1'b1;
        end else begin
            pend   <= pend_nx;
            enable <= enable_nx;
            mode   <= mode_nx;
            src_q  <= src8;
            phi2_q <= bus.phi2;
            irq    <= ~|(pend_nx & enable_nx);
        end
    end

    assign active = pend & enable;

    always_comb begin
        vect    = '0;
        vect[7] = |active;
        for (int unsigned i = 8; i > 0; i--) begin
            if (active[i-1]) vect[2:0] = 3'(i - 1);
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (off)
                2'd0:    bus.rdata = pend;
                2'd1:    bus.rdata = enable;
                2'd2:    bus.rdata = mode;
                default: bus.rdata = vect;
            endcase
        end
    end

    assign nmi_edge = nmi_src & ~nmi_src_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            nmi_pend  <= 1'b0;
            nmi_src_q <= 1'b0;
            nmi       <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            nmi_pend  <= nmi_pend_nx;
            nmi_src_q <= nmi_src;
            nmi       <= nmi_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        nmi_pend_nx = nmi_pend;
        unique case (state)
            IDLE: begin
                if (nmi_edge) begin
                    state_nx = LOW;
                    cnt_nx   = CW'(NMI_PULSE - 1);
                end
            end
            LOW: begin
                if (nmi_edge) nmi_pend_nx = 1'b1;
                if (cnt == '0) begin
                    state_nx = GAP;
                    cnt_nx   = CW'(NMI_GAP - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                    if (nmi_edge) nmi_pend_nx = 1'b1;
                end else if (nmi_pend || nmi_edge) begin
                    // An edge arriving as the pending pulse starts becomes the new pending one.
                    state_nx    = LOW;
                    cnt_nx      = CW'(NMI_PULSE - 1);
                    nmi_pend_nx = nmi_pend & nmi_edge;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        nmi_nx = (state != LOW);
    end
endmodule
